submaster_rd_engine: RTL and testbench
======================================

// Module: submaster_rd_engine
// PURPOSE
//  Read submaster behind the submaster read arbiter: takes one read command, requests the AXI read channel
//  via start/grant/xfer_done, issues one INCR AR burst, streams R beats out through a registered output
//  stage, then releases the arbiter. One instance per arbiter port (0..3), all sharing one AXI AR/R bus.
// PARAMETERS
//  ADDR_W   32  AXI/command address width
//  DATA_W   32  R data width; arsize = log2(DATA_W/8)
//  ID_W     4   AXI ID width
//  MST_ID   0   fixed ARID driven by this submaster; R beats with other RID are ignored (rready held 0)
// PORTS
//  clk          in   1       clock
//  reset_n      in   1       asynchronous active-low reset
//  cmd_valid    in   1       read command valid
//  cmd_ready    out  1       command accepted when cmd_valid&cmd_ready
//  cmd_addr     in   ADDR_W  burst start address, DATA_W/8-aligned
//  cmd_len      in   8       beats-1 (AXI ARLEN encoding)
//  start        out  1       request to arbiter (arbiter start_N)
//  grant        in   1       one-cycle grant from arbiter (grant_N)
//  xfer_done    out  1       one-cycle release to arbiter (xfer_done_N)
//  arvalid/arready out/in 1  AR handshake
//  araddr       out  ADDR_W  latched cmd_addr
//  arlen        out  8       latched cmd_len
//  arsize       out  3       log2(DATA_W/8); arburst out 2 = 2'b01 (INCR); arid out ID_W = MST_ID
//  rvalid/rready in/out 1    R handshake
//  rdata        in   DATA_W; rresp in 2; rlast in 1; rid in ID_W
//  out_valid/out_ready out/in 1  read data stream handshake
//  out_data     out  DATA_W  registered rdata; out_last out 1 = last beat of burst
//  busy         out  1       state != IDLE
//  err          out  1       sticky: any SLVERR/DECERR or rlast/length mismatch in current command
// BEHAVIOUR
//  Reset: state IDLE; start, xfer_done, arvalid, rready, out_valid, out_last, busy, err = 0; cmd_ready = 1;
//   araddr/arlen/out_data = 0, beat counter = 0. Reset mid-burst abandons the burst (arbiter shares reset_n).
//  FSM (registered state, all control outputs decoded from state/registers, no input->output comb paths
//   except rready):
//   IDLE : cmd_ready=1. On cmd_valid: latch addr/len, clear err and beat_cnt -> REQ (start=1 next cycle).
//   REQ  : start=1. On grant: -> ADDR; start drops the cycle after grant (must be low before xfer_done so
//          arbiter does not re-grant). grant seen outside REQ is ignored.
//   ADDR : arvalid=1, araddr/arlen stable until arready; on arvalid&arready -> DATA.
//   DATA : rready = (rid==MST_ID) & (!out_valid | out_ready). Each accepted beat: out_data<=rdata,
//          out_valid<=1, out_last<=(beat_cnt==arlen), beat_cnt+=1 (8-bit). rresp[1]=1 sets err.
//          rlast with beat_cnt!=arlen (early) or beat_cnt==arlen without rlast (late) sets err; burst
//          ends on rlast OR beat_cnt==arlen, whichever first -> DRAIN.
//   DRAIN: rready=0; wait until output stage empty (out_valid=0 or out_valid&out_ready) -> DONE.
//   DONE : xfer_done=1 for exactly one cycle -> IDLE. err holds until next command accepted.
//  Output stage: out_valid clears on out_ready when no new beat loaded same cycle; simultaneous load and
//   unload keeps out_valid=1. Backpressure (out_ready=0) stalls rready; no beat lost or duplicated.
//  Latency: cmd accept -> start: 1 cycle; grant -> arvalid: 1 cycle; rlast beat -> xfer_done: >=2 cycles.
//  cmd_len=0: single beat; out_last=1 on that beat. cmd_len=255: 256 beats, beat_cnt wraps to 0 at end.
//  Only one command outstanding; cmd_ready=0 in every state except IDLE.
// TESTING
//  1 cmd addr=0x1000 len=3, grant 2 cycles after start, arready=1, 4 R beats rlast on 4th, out_ready=1
//    -> ARADDR=0x1000 ARLEN=3 ARBURST=1, 4 out beats in order, out_last on 4th, xfer_done one pulse, err=0.
//  2 Same, out_ready toggles 1/0 each cycle, rvalid always 1 -> rready follows stage, all 4 beats once.
//  3 len=0, arready delayed 5 cycles -> arvalid/araddr stable 6 cycles, 1 beat out_last=1, xfer_done once.
//  4 len=3, rlast on beat 2 -> burst ends after beat 2, err=1, xfer_done pulses; next cmd clears err.
//  5 rresp=2'b10 on beat 1 of len=1 -> both beats delivered, err=1 sticky until next accept.
//  6 reset_n low during DATA beat 2 -> all outputs reset values same cycle, cmd_ready=1 after release.

Source files
------------

// File: rtl/submaster_rd_engine.sv
// Read submaster: accepts one read command, arbitrates for the shared AXI read
// channel, issues one INCR AR burst and streams R beats through a registered stage.
module submaster_rd_engine #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ID_W   = 4,
  parameter int unsigned MST_ID = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  // command
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [7:0]        cmd_len,
  // arbiter
  output logic              start,
  input  logic              grant,
  output logic              xfer_done,
  // AXI AR
  output logic              arvalid,
  input  logic              arready,
  output logic [ADDR_W-1:0] araddr,
  output logic [7:0]        arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  output logic [ID_W-1:0]   arid,
  // AXI R
  input  logic              rvalid,
  output logic              rready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rlast,
  input  logic [ID_W-1:0]   rid,
  // read data stream
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  // status
  output logic              busy,
  output logic              err
);

  localparam int unsigned LEN_W  = 8;
  localparam int unsigned SIZE_W = 3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    ADDR  = 3'd2,
    DATA  = 3'd3,
    DRAIN = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [LEN_W-1:0]   beat_cnt_q;

  logic stage_free_c;
  logic r_fire_c;
  logic len_hit_c;
  logic beat_end_c;
  logic err_beat_c;
  logic cmd_fire_c;

  // Control outputs decode straight from the state register.
  assign cmd_ready = (state_q == IDLE);
  assign start     = (state_q == REQ);
  assign arvalid   = (state_q == ADDR);
  assign xfer_done = (state_q == DONE);
  assign busy      = (state_q != IDLE);

  assign arsize  = SIZE_W'($clog2(DATA_W / 8));
  assign arburst = 2'b01;
  assign arid    = ID_W'(MST_ID);

  // Beats for other submasters are left on the bus untouched.
  assign stage_free_c = !out_valid || out_ready;
  assign rready       = (state_q == DATA) && (rid == ID_W'(MST_ID)) && stage_free_c;
  assign r_fire_c     = rvalid && rready;
  assign cmd_fire_c   = cmd_valid && cmd_ready;

  // Burst ends on rlast or the expected final beat, whichever comes first.
  assign len_hit_c  = (beat_cnt_q == arlen);
  assign beat_end_c = r_fire_c && (rlast || len_hit_c);
  assign err_beat_c = r_fire_c && ((rresp >= 2'b10) || (rlast != len_hit_c));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cmd_valid)    state_d = REQ;
      REQ:     if (grant)        state_d = ADDR;
      ADDR:    if (arready)      state_d = DATA;
      DATA:    if (beat_end_c)   state_d = DRAIN;
      DRAIN:   if (stage_free_c) state_d = DONE;
      DONE:                      state_d = IDLE;
      default:                   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Command latch, beat counter and sticky error.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      araddr     <= '0;
      arlen      <= '0;
      beat_cnt_q <= '0;
      err        <= 1'b0;
    end else if (cmd_fire_c) begin
      araddr     <= cmd_addr;
      arlen      <= cmd_len;
      beat_cnt_q <= '0;
      err        <= 1'b0;
    end else begin
      if (r_fire_c) begin
        beat_cnt_q <= beat_cnt_q + LEN_W'(1);
      end
      if (err_beat_c) begin
        err <= 1'b1;
      end
    end
  end

  // Single-entry output stage; a load in the same cycle as an unload keeps it full.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else if (r_fire_c) begin
      out_valid <= 1'b1;
      out_last  <= len_hit_c;
      out_data  <= rdata;
    end else if (out_ready) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_submaster_rd_engine.sv
// Directed bench for submaster_rd_engine: a cycle-stepped arbiter/AXI slave model
// drives each scenario and every test task checks the recorded outcome.
module tb_submaster_rd_engine;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ID_W   = 4;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_addr;
  logic [7:0]        cmd_len;
  logic              start;
  logic              grant;
  logic              xfer_done;
  logic              arvalid;
  logic              arready;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic [ID_W-1:0]   arid;
  logic              rvalid;
  logic              rready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic [ID_W-1:0]   rid;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              busy;
  logic              err;

  submaster_rd_engine #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .MST_ID(0)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .start(start), .grant(grant), .xfer_done(xfer_done),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen),
    .arsize(arsize), .arburst(arburst), .arid(arid),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rid(rid),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Results recorded by run_burst
  logic [DATA_W-1:0] q_data[$];
  logic              q_last[$];
  int   xfer_cnt, start_cnt, grant_cyc, arv_first, arv_cnt, ar_bad, rdy_bad;
  bit   timed_out;
  logic cmdrdy_before, err_before, err_after_accept, start_after_accept;
  logic err_end, busy_end, cmdrdy_end;

  // Issue one command and play arbiter + AXI slave, one negedge per cycle.
  task automatic run_burst(input logic [ADDR_W-1:0] addr, input logic [7:0] len,
                           input int grant_dly, input int ar_dly, input int rlast_beat,
                           input int nbeats, input int resp_err_beat, input bit toggle_rdy);
    int cyc = 0, gcnt = 0, post = 0, beats_sent = 0;
    bit granted = 0, ar_done = 0, xfer_seen = 0;
    q_data.delete(); q_last.delete();
    xfer_cnt = 0; start_cnt = 0; grant_cyc = -100; arv_first = -1; arv_cnt = 0;
    ar_bad = 0; rdy_bad = 0;
    cmdrdy_before = cmd_ready;
    err_before = err;
    cmd_valid = 1'b1; cmd_addr = addr; cmd_len = len;
    @(negedge clk);
    cmd_valid = 1'b0;
    err_after_accept = err;
    start_after_accept = start;
    while (cyc < 3000 && post < 3) begin
      if (xfer_seen) post++;
      if (xfer_done) begin xfer_cnt++; xfer_seen = 1; end
      if (start) start_cnt++;
      grant = 1'b0; arready = 1'b0;
      if (start && !granted) begin
        if (gcnt == grant_dly) begin grant = 1'b1; granted = 1; grant_cyc = cyc; end
        gcnt++;
      end
      if (arvalid) begin
        if (arv_cnt == 0) arv_first = cyc;
        arv_cnt++;
        if (araddr !== addr || arlen !== len || arburst !== 2'b01) ar_bad++;
        if (arv_cnt > ar_dly) arready = 1'b1;
      end
      rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00; rid = 4'd0;
      if (ar_done && beats_sent < nbeats) begin
        rvalid = 1'b1;
        rdata  = {16'hDA7A, len, 8'(beats_sent)};
        rlast  = (beats_sent == rlast_beat);
        rresp  = (beats_sent == resp_err_beat) ? 2'b10 : 2'b00;
      end
      out_ready = toggle_rdy ? ((cyc % 2) == 0) : 1'b1;
      #1;
      if (out_valid && !out_ready && rready) rdy_bad++;
      if (rvalid && rready) beats_sent++;
      if (out_valid && out_ready) begin q_data.push_back(out_data); q_last.push_back(out_last); end
      if (arvalid && arready) ar_done = 1;
      @(negedge clk);
      cyc++;
    end
    timed_out = !xfer_seen;
    rvalid = 1'b0; rlast = 1'b0; grant = 1'b0; arready = 1'b0; out_ready = 1'b1;
    err_end = err; busy_end = busy; cmdrdy_end = cmd_ready;
  endtask

  task automatic test_reset();
    logic [8:0] got;
    got = {start, xfer_done, arvalid, rready, out_valid, out_last, busy, err, cmd_ready};
    checks++;
    if (got !== 9'b0_0000_0001) begin
      errors++; $display("FAIL reset_ctrl got %b exp %b", got, 9'b0_0000_0001);
    end
    checks++;
    if (araddr !== '0 || arlen !== 8'd0 || out_data !== '0) begin
      errors++; $display("FAIL reset_regs got %h/%h/%h exp 0/0/0", araddr, arlen, out_data);
    end
    checks++;
    if (arsize !== 3'd2 || arburst !== 2'b01 || arid !== 4'd0) begin
      errors++; $display("FAIL reset_const got %0d/%0d/%0d exp 2/1/0", arsize, arburst, arid);
    end
  endtask

  task automatic test_basic();
    run_burst(32'h1000, 8'd3, 2, 0, 3, 4, -1, 1'b0);
    checks++;
    if (timed_out) begin errors++; $display("FAIL basic_timeout got no xfer_done exp pulse"); end
    checks++;
    if (cmdrdy_before !== 1'b1 || start_after_accept !== 1'b1) begin
      errors++; $display("FAIL basic_accept got rdy=%b start=%b exp 1/1", cmdrdy_before, start_after_accept);
    end
    checks++;
    if (start_cnt !== 3) begin errors++; $display("FAIL basic_start_len got %0d exp 3", start_cnt); end
    checks++;
    if (arv_first - grant_cyc !== 1 || ar_bad !== 0 || arv_cnt !== 1) begin
      errors++; $display("FAIL basic_ar got lat=%0d bad=%0d cnt=%0d exp 1/0/1", arv_first - grant_cyc, ar_bad, arv_cnt);
    end
    checks++;
    if (q_data.size() !== 4) begin errors++; $display("FAIL basic_nbeats got %0d exp 4", q_data.size()); end
    for (int i = 0; i < q_data.size() && i < 4; i++) begin
      checks++;
      if (q_data[i] !== {16'hDA7A, 8'd3, 8'(i)} || q_last[i] !== (i == 3)) begin
        errors++; $display("FAIL basic_beat%0d got %h last=%b exp %h last=%b", i, q_data[i], q_last[i],
                           {16'hDA7A, 8'd3, 8'(i)}, (i == 3));
      end
    end
    checks++;
    if (xfer_cnt !== 1 || err_end !== 1'b0 || busy_end !== 1'b0 || cmdrdy_end !== 1'b1) begin
      errors++; $display("FAIL basic_end got xfer=%0d err=%b busy=%b rdy=%b exp 1/0/0/1",
                         xfer_cnt, err_end, busy_end, cmdrdy_end);
    end
  endtask

  task automatic test_backpressure();
    run_burst(32'h1000, 8'd3, 2, 0, 3, 4, -1, 1'b1);
    checks++;
    if (timed_out || rdy_bad !== 0) begin
      errors++; $display("FAIL bp_rready got to=%b bad=%0d exp 0/0", timed_out, rdy_bad);
    end
    checks++;
    if (q_data.size() !== 4) begin errors++; $display("FAIL bp_nbeats got %0d exp 4", q_data.size()); end
    for (int i = 0; i < q_data.size() && i < 4; i++) begin
      checks++;
      if (q_data[i] !== {16'hDA7A, 8'd3, 8'(i)} || q_last[i] !== (i == 3)) begin
        errors++; $display("FAIL bp_beat%0d got %h last=%b exp %h last=%b", i, q_data[i], q_last[i],
                           {16'hDA7A, 8'd3, 8'(i)}, (i == 3));
      end
    end
    checks++;
    if (xfer_cnt !== 1 || err_end !== 1'b0) begin
      errors++; $display("FAIL bp_end got xfer=%0d err=%b exp 1/0", xfer_cnt, err_end);
    end
  endtask

  task automatic test_single_slow_ar();
    run_burst(32'h0000_2040, 8'd0, 0, 5, 0, 1, -1, 1'b0);
    checks++;
    if (arv_cnt !== 6 || ar_bad !== 0) begin
      errors++; $display("FAIL single_ar got cnt=%0d bad=%0d exp 6/0", arv_cnt, ar_bad);
    end
    checks++;
    if (q_data.size() !== 1 || q_last.size() !== 1 || q_last[0] !== 1'b1) begin
      errors++; $display("FAIL single_beat got n=%0d exp 1 with last", q_data.size());
    end
    checks++;
    if (xfer_cnt !== 1 || err_end !== 1'b0) begin
      errors++; $display("FAIL single_end got xfer=%0d err=%b exp 1/0", xfer_cnt, err_end);
    end
  endtask

  task automatic test_clear_after_err(input string tag);
    run_burst(32'h2000, 8'd1, 1, 0, 1, 2, -1, 1'b0);
    checks++;
    if (err_before !== 1'b1 || err_after_accept !== 1'b0 || err_end !== 1'b0) begin
      errors++; $display("FAIL %s_clear got before=%b accept=%b end=%b exp 1/0/0",
                         tag, err_before, err_after_accept, err_end);
    end
  endtask

  task automatic test_early_rlast();
    run_burst(32'h1100, 8'd3, 0, 0, 1, 2, -1, 1'b0);
    checks++;
    if (timed_out || xfer_cnt !== 1) begin
      errors++; $display("FAIL early_xfer got to=%b xfer=%0d exp 0/1", timed_out, xfer_cnt);
    end
    checks++;
    if (q_data.size() !== 2 || err_end !== 1'b1) begin
      errors++; $display("FAIL early_err got n=%0d err=%b exp 2/1", q_data.size(), err_end);
    end
    test_clear_after_err("early");
  endtask

  task automatic test_resp_err();
    run_burst(32'h1200, 8'd1, 0, 0, 1, 2, 0, 1'b0);
    checks++;
    if (q_data.size() !== 2 || q_last.size() !== 2 || q_last[1] !== 1'b1) begin
      errors++; $display("FAIL resp_beats got n=%0d exp 2 with last", q_data.size());
    end
    checks++;
    if (err_end !== 1'b1 || xfer_cnt !== 1) begin
      errors++; $display("FAIL resp_err got err=%b xfer=%0d exp 1/1", err_end, xfer_cnt);
    end
    repeat (3) @(negedge clk);
    test_clear_after_err("resp");
  endtask

  task automatic test_max_len();
    int nlast = 0;
    int bad = 0;
    run_burst(32'h4000, 8'd255, 0, 0, 255, 256, -1, 1'b0);
    checks++;
    if (q_data.size() !== 256) begin errors++; $display("FAIL max_nbeats got %0d exp 256", q_data.size()); end
    for (int i = 0; i < q_data.size(); i++) begin
      if (q_last[i]) nlast++;
      if (q_data[i] !== {16'hDA7A, 8'hFF, 8'(i)}) bad++;
    end
    checks++;
    if (nlast !== 1 || q_last.size() !== 256 || q_last[255] !== 1'b1 || bad !== 0) begin
      errors++; $display("FAIL max_last got nlast=%0d bad=%0d exp 1/0", nlast, bad);
    end
    checks++;
    if (err_end !== 1'b0 || xfer_cnt !== 1) begin
      errors++; $display("FAIL max_end got err=%b xfer=%0d exp 0/1", err_end, xfer_cnt);
    end
  endtask

  task automatic test_reset_mid();
    logic [8:0] got;
    cmd_valid = 1'b1; cmd_addr = 32'h3000; cmd_len = 8'd3;
    @(negedge clk);
    cmd_valid = 1'b0; grant = 1'b1;
    @(negedge clk);
    grant = 1'b0; arready = 1'b1;
    @(negedge clk);
    arready = 1'b0; rvalid = 1'b1; rdata = 32'hA0; rlast = 1'b0; rresp = 2'b00; rid = 4'd0;
    out_ready = 1'b1;
    @(negedge clk);
    rdata = 32'hA1;
    #1;
    checks++;
    if (rready !== 1'b1 || out_valid !== 1'b1 || out_data !== 32'hA0) begin
      errors++; $display("FAIL rstmid_pre got rready=%b ov=%b d=%h exp 1/1/a0", rready, out_valid, out_data);
    end
    reset_n = 1'b0;
    #1;
    got = {start, xfer_done, arvalid, rready, out_valid, out_last, busy, err, cmd_ready};
    checks++;
    if (got !== 9'b0_0000_0001 || araddr !== '0 || arlen !== 8'd0 || out_data !== '0) begin
      errors++; $display("FAIL rstmid_outs got %b %h %h %h exp 000000001 0 0 0", got, araddr, arlen, out_data);
    end
    rvalid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL rstmid_release got rdy=%b busy=%b exp 1/0", cmd_ready, busy);
    end
    run_burst(32'h3000, 8'd0, 0, 0, 0, 1, -1, 1'b0);
    checks++;
    if (timed_out || q_data.size() !== 1 || xfer_cnt !== 1) begin
      errors++; $display("FAIL rstmid_recover got to=%b n=%0d xfer=%0d exp 0/1/1", timed_out, q_data.size(), xfer_cnt);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0;
    grant = 1'b0; arready = 1'b0;
    rvalid = 1'b0; rdata = '0; rresp = 2'b00; rlast = 1'b0; rid = '0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    test_reset();
    reset_n = 1'b1;
    @(negedge clk);
    test_basic();
    test_backpressure();
    test_single_slow_ar();
    test_early_rlast();
    test_resp_err();
    test_max_len();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
